// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch front-end control stage:
// FSM state encoding, key index constants, default timing values and the
// pure next-state decode used by the control FSM.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      LAP     = 2'd3
   } state_t;

   localparam int KEY_START = 0;
   localparam int KEY_LAP   = 1;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;    // 20 ms at 50 MHz
   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_LONG_CYCLES     = 100000000;  // 2 s at 50 MHz

   typedef struct packed {
      state_t state;
      logic   clear;
   } step_t;

   // Next state and clear request for one clock. A long-press hit overrides
   // everything; otherwise the lap/clear key wins over start/stop when both
   // press events land in the same clock.
   function automatic step_t fsm_step(input state_t cur,
                                      input logic   press_start,
                                      input logic   press_lap,
                                      input logic   long_hit);
      step_t s;
      // NOTE: defaults first so every path assigns, keeping the decode purely combinational.
      s.state = cur;
      s.clear = 1'b0;
      if (long_hit) begin
         s.state = STOPPED;
         s.clear = 1'b1;
      end else if (press_lap) begin
         case (cur)
            STOPPED: begin s.state = STOPPED; s.clear = 1'b1; end
            RUNNING: s.state = LAP;
            LAP:     s.state = RUNNING;
            PAUSED:  begin s.state = STOPPED; s.clear = 1'b1; end
            default: s.state = STOPPED;
         endcase
      end else if (press_start) begin
         case (cur)
            STOPPED: s.state = RUNNING;
            RUNNING: s.state = PAUSED;
            LAP:     s.state = PAUSED;
            PAUSED:  s.state = RUNNING;
            default: s.state = STOPPED;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and control outputs of the stopwatch front-end, bundled so the
// datapath side (master) and the controller (slave) share one connection.
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic [1:0] key_n;    // raw active-low buttons: [0] start/stop, [1] lap/clear
   logic       run;      // count enable level
   logic       freeze;   // display holds the latched lap value
   logic       clear;    // one-clk counter reset pulse
   state_t     state_o;  // current FSM state for debug LEDs

   modport master (output key_n, input run, freeze, clear, state_o);
   modport slave  (input key_n, output run, freeze, clear, state_o);
endinterface

// File: rtl/stopwatch_ctrl_key_debounce.sv
// One push-button front-end: SYNC_STAGES-deep synchroniser, saturating
// debounce counter that accepts a new level after DEBOUNCE_CYCLES identical
// samples, and a one-clk press pulse on the accepted 1->0 transition.
module key_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_raw,
   output logic level,
   output logic press
);

   localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CW-1:0]          cnt;

   // Plain shift-register synchroniser; resets to the released level.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_raw};
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Count consecutive differing samples; accept the new level and flag a press on 1->0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (synced == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= synced;
            cnt   <= '0;
            press <= ~synced;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end control stage: debounces the start/stop and lap/clear
// keys and runs the STOPPED/RUNNING/PAUSED/LAP state machine that drives
// run, freeze and the one-clk clear pulse. Outputs are registered from the
// next state.
// Optional build macro: STOPWATCH_CTRL_LONGPRESS_EN adds a long-press clear
// on the lap/clear key after LONG_CYCLES of continuous hold.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
   input logic             clk,
   input logic             rst_n,
   stopwatch_ctrl_if.slave bus
);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2) begin : g_param_check
      $error("stopwatch_ctrl: SYNC_STAGES >= 2, DEBOUNCE_CYCLES >= 1, LONG_CYCLES >= 2 required");
   end

   logic   start_level, lap_level;
   logic   press_start, press_lap;
   logic   long_hit;
   state_t state;
   logic   run_lvl, freeze_lvl, clear_pulse;
   step_t  step;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_key_start (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_raw (bus.key_n[KEY_START]),
      .level     (start_level),
      .press     (press_start)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_key_lap (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_raw (bus.key_n[KEY_LAP]),
      .level     (lap_level),
      .press     (press_lap)
   );

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
   localparam int            HW        = $clog2(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   logic [HW-1:0] hold_cnt;
   logic          lockout;
   logic          unused_level;

   assign unused_level = start_level;

   // Time the debounced lap key hold; lock out repeats until the key is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         lockout  <= 1'b0;
      end else if (lap_level) begin
         hold_cnt <= '0;
         lockout  <= 1'b0;
      end else if (!lockout) begin
         if (hold_cnt == HOLD_LAST) lockout  <= 1'b1;
         else                       hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign long_hit = !lap_level && !lockout && (hold_cnt == HOLD_LAST);
`else
   logic unused_levels;

   assign unused_levels = start_level ^ lap_level;
   assign long_hit      = 1'b0;
`endif

   assign step = fsm_step(state, press_start, press_lap, long_hit);

   // Control FSM; outputs are registered and decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= STOPPED;
         run_lvl     <= 1'b0;
         freeze_lvl  <= 1'b0;
         clear_pulse <= 1'b0;
      end else begin
         state       <= step.state;
         run_lvl     <= (step.state == RUNNING) || (step.state == LAP);
         freeze_lvl  <= (step.state == LAP);
         clear_pulse <= step.clear;
      end
   end

   assign bus.run     = run_lvl;
   assign bus.freeze  = freeze_lvl;
   assign bus.clear   = clear_pulse;
   assign bus.state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with short timing parameters.
// A behavioural model (sample-history debounce, table-driven FSM) runs in
// parallel; a monitor counts cycles where the DUT disagrees with it, and the
// scenario tasks compare against the model and against fixed expectations.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int S = 2;
   localparam int D = 4;
   localparam int L = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .SYNC_STAGES     (S),
      .LONG_CYCLES     (L)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- behavioural reference model ----------------
   logic [1:0] nxt_start [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
   logic [1:0] nxt_lap   [4] = '{2'd0, 2'd3, 2'd0, 2'd1};
   bit         clr_lap   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   logic [1:0] m_state;
   bit         m_run, m_freeze, m_clear;
   bit [15:0]  hist [2];
   bit         lvl [2];
   bit         pend [2];
   bit         long_pend, fired;
   int         low_cnt;
   int         m_clears = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 2'd0; m_run = 0; m_freeze = 0; m_clear = 0;
         for (int k = 0; k < 2; k++) begin
            hist[k] = '1; lvl[k] = 1'b1; pend[k] = 1'b0;
         end
         long_pend = 0; fired = 0; low_cnt = 0;
      end else begin
         bit old_lap;
         m_clear = 0;
         if (long_pend) begin
            m_state = 2'd0; m_clear = 1;
         end else if (pend[1]) begin
            m_clear = clr_lap[m_state]; m_state = nxt_lap[m_state];
         end else if (pend[0]) begin
            m_state = nxt_start[m_state];
         end
         m_run    = (m_state == 2'd1) || (m_state == 2'd3);
         m_freeze = (m_state == 2'd3);
         if (m_clear) m_clears++;
         old_lap = lvl[1];
         // A level is accepted once D consecutive synchronised samples disagree with it.
         for (int k = 0; k < 2; k++) begin
            bit all_new;
            hist[k] = {hist[k][14:0], bus.key_n[k]};
            pend[k] = 1'b0;
            all_new = 1'b1;
            for (int j = S; j < S + D; j++) if (hist[k][j] == lvl[k]) all_new = 1'b0;
            if (all_new) begin
               lvl[k]  = ~lvl[k];
               pend[k] = ~lvl[k];
            end
         end
         long_pend = 0;
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
         if (old_lap) begin
            low_cnt = 0; fired = 0;
         end else begin
            if (low_cnt < L) low_cnt++;
            if (low_cnt == L - 1 && !fired && !lvl[1]) begin
               long_pend = 1; fired = 1;
            end
         end
`endif
      end
   end

   // ---------------- monitor ----------------
   int  mm_count   = 0;
   time mm_first   = 0;
   int  dut_clears = 0;
   bit  saw_running = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if ({bus.state_o, bus.run, bus.freeze, bus.clear} !== {m_state, m_run, m_freeze, m_clear}) begin
            mm_count++;
            if (mm_count == 1) mm_first = $time;
         end
         if (bus.clear === 1'b1) dut_clears++;
         if (bus.state_o === RUNNING) saw_running = 1;
      end
   end

   // ---------------- stimulus helpers (no comparisons) ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tap(input logic [1:0] mask, input int hold, input int gap);
      bus.key_n = ~mask;
      wait_cycles(hold);
      bus.key_n = 2'b11;
      wait_cycles(gap);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int bad;
      bus.key_n = 2'b11;
      #2 rst_n = 1'b0;
      wait_cycles(3);
      n_checks++;
      if ({bus.state_o, bus.run, bus.freeze, bus.clear} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_values: got %b required 00000", {bus.state_o, bus.run, bus.freeze, bus.clear});
      end
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ({bus.state_o, bus.run, bus.freeze, bus.clear} !== 5'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL idle_after_reset: %0d nonzero cycles, required 0", bad);
      end
   endtask

   task automatic test_glitch();
      int g, mm0;
      mm0 = mm_count;
      g = $urandom_range(D - 1, 1);
      tap(2'b01, g, 12);
      n_checks++;
      if (bus.state_o !== STOPPED || bus.run !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_ignored: state %0d run %b (glitch %0d clk), required 0/0", bus.state_o, bus.run, g);
      end
      n_checks++;
      if (mm_count !== mm0) begin
         n_fail++;
         $display("FAIL glitch_model: %0d mismatching cycles, required 0", mm_count - mm0);
      end
   endtask

   task automatic test_start();
      int lat, c0;
      bit found;
      c0 = dut_clears; found = 0; lat = 0;
      bus.key_n[0] = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!found && bus.run === 1'b1) begin found = 1; lat = i; end
         if (i == 10) bus.key_n[0] = 1'b1;
      end
      n_checks++;
      if (!found || lat < S + D || lat > S + D + 2) begin
         n_fail++;
         $display("FAIL start_latency: got %0d (found %b), required %0d +/-1", lat, found, S + D + 1);
      end
      n_checks++;
      if (bus.state_o !== RUNNING || bus.state_o !== m_state) begin
         n_fail++;
         $display("FAIL start_state: got %0d required %0d", bus.state_o, RUNNING);
      end
      n_checks++;
      if (dut_clears !== c0) begin
         n_fail++;
         $display("FAIL start_no_clear: got %0d clears required 0", dut_clears - c0);
      end
   endtask

   task automatic test_lap();
      tap(2'b10, $urandom_range(12, 6), 12);
      n_checks++;
      if ({bus.state_o, bus.freeze, bus.run} !== {LAP, 1'b1, 1'b1} || bus.state_o !== m_state) begin
         n_fail++;
         $display("FAIL lap_enter: state %0d freeze %b run %b, required 3/1/1", bus.state_o, bus.freeze, bus.run);
      end
      tap(2'b10, $urandom_range(12, 6), 12);
      n_checks++;
      if ({bus.state_o, bus.freeze, bus.run} !== {RUNNING, 1'b0, 1'b1} || bus.state_o !== m_state) begin
         n_fail++;
         $display("FAIL lap_exit: state %0d freeze %b run %b, required 1/0/1", bus.state_o, bus.freeze, bus.run);
      end
   endtask

   task automatic test_pause_clear();
      int c0, mc0;
      tap(2'b01, $urandom_range(12, 6), 12);
      n_checks++;
      if (bus.state_o !== PAUSED || bus.run !== 1'b0) begin
         n_fail++;
         $display("FAIL pause: state %0d run %b, required 2/0", bus.state_o, bus.run);
      end
      c0 = dut_clears; mc0 = m_clears;
      tap(2'b10, $urandom_range(12, 6), 12);
      n_checks++;
      if (bus.state_o !== STOPPED || (dut_clears - c0) !== 1 || (m_clears - mc0) !== 1) begin
         n_fail++;
         $display("FAIL pause_clear: state %0d clear pulses %0d, required 0/1", bus.state_o, dut_clears - c0);
      end
   endtask

   task automatic test_simultaneous();
      int c0;
      tap(2'b01, 8, 12);
      tap(2'b01, 8, 12);
      n_checks++;
      if (bus.state_o !== PAUSED) begin
         n_fail++;
         $display("FAIL simul_setup: state %0d required 2", bus.state_o);
      end
      c0 = dut_clears; saw_running = 0;
      tap(2'b11, $urandom_range(12, 6), 12);
      n_checks++;
      if (bus.state_o !== STOPPED || (dut_clears - c0) !== 1 || saw_running !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_press: state %0d clears %0d saw_running %b, required 0/1/0",
                  bus.state_o, dut_clears - c0, saw_running);
      end
   endtask

   task automatic test_held_through_reset();
      bus.key_n = 2'b10;
      #2 rst_n = 1'b0;
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(10);
      bus.key_n = 2'b11;
      wait_cycles(12);
      n_checks++;
      if (bus.state_o !== RUNNING || bus.state_o !== m_state) begin
         n_fail++;
         $display("FAIL held_through_reset: state %0d required %0d", bus.state_o, RUNNING);
      end
   endtask

   task automatic test_async_reset();
      int c0;
      tap(2'b10, 8, 12);
      n_checks++;
      if (bus.state_o !== LAP) begin
         n_fail++;
         $display("FAIL async_setup: state %0d required 3", bus.state_o);
      end
      c0 = dut_clears;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.state_o, bus.run, bus.freeze, bus.clear} !== 5'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %b required 00000", {bus.state_o, bus.run, bus.freeze, bus.clear});
      end
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(12);
      n_checks++;
      if (dut_clears !== c0 || bus.state_o !== STOPPED) begin
         n_fail++;
         $display("FAIL reset_no_clear: clears %0d state %0d, required 0/0", dut_clears - c0, bus.state_o);
      end
   endtask

   task automatic test_random();
      int mm0, c0, mc0;
      mm0 = mm_count; c0 = dut_clears; mc0 = m_clears;
      for (int i = 0; i < 40; i++)
         tap(2'($urandom_range(3, 1)), $urandom_range(12, 1), $urandom_range(14, 1));
      wait_cycles(12);
      n_checks++;
      if (mm_count !== mm0) begin
         n_fail++;
         $display("FAIL random_model: %0d mismatching cycles (first at %0t), required 0", mm_count - mm0, mm_first);
      end
      n_checks++;
      if ((dut_clears - c0) !== (m_clears - mc0)) begin
         n_fail++;
         $display("FAIL random_clears: got %0d required %0d", dut_clears - c0, m_clears - mc0);
      end
      n_checks++;
      if (bus.state_o !== m_state) begin
         n_fail++;
         $display("FAIL random_state: got %0d required %0d", bus.state_o, m_state);
      end
   endtask

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
   task automatic test_longpress();
      int c0, stop_at;
      state_t st10;
      #2 rst_n = 1'b0;
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(4);
      tap(2'b01, 8, 12);
      c0 = dut_clears; stop_at = 0; st10 = STOPPED;
      bus.key_n[1] = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 10) st10 = bus.state_o;
         if (stop_at == 0 && i > 10 && bus.state_o === STOPPED) stop_at = i;
      end
      bus.key_n[1] = 1'b1;
      wait_cycles(12);
      n_checks++;
      if (st10 !== LAP) begin
         n_fail++;
         $display("FAIL long_short_action: state %0d required 3", st10);
      end
      n_checks++;
      if (stop_at < S + D + L - 1 || stop_at > S + D + L + 1) begin
         n_fail++;
         $display("FAIL long_timing: stopped at %0d required %0d +/-1", stop_at, S + D + L);
      end
      n_checks++;
      if ((dut_clears - c0) !== 1 || bus.state_o !== STOPPED) begin
         n_fail++;
         $display("FAIL long_clear_once: clears %0d state %0d, required 1/0", dut_clears - c0, bus.state_o);
      end
      tap(2'b01, 8, 12);
      bus.key_n[1] = 1'b0;
      wait_cycles(12);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.state_o, bus.run, bus.freeze, bus.clear} !== 5'b0) begin
         n_fail++;
         $display("FAIL long_async_reset: got %b required 00000", {bus.state_o, bus.run, bus.freeze, bus.clear});
      end
      bus.key_n = 2'b11;
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(12);
   endtask
`endif

   initial begin
      bus.key_n = 2'b11;
      test_reset();
      test_glitch();
      test_start();
      test_lap();
      test_pause_clear();
      test_simultaneous();
      test_held_through_reset();
      test_async_reset();
      test_random();
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
      test_longpress();
`endif
      n_checks++;
      if (mm_count !== 0) begin
         n_fail++;
         $display("FAIL model_overall: %0d mismatching cycles (first at %0t), required 0", mm_count, mm_first);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
